// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered 3-bit grant index
// and an internal 3-to-8 decode of that index into a one-hot grant vector.
// Optional feature macro: ARB_TIMEOUT_EN (forced revoke after MAX_HOLD cycles
// when other requesters are waiting). Default build: feature disabled.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       arb_en,
  input  logic [7:0] req,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout_pls
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic             vld_q, vld_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // First set bit of v scanning p, p+1, ..., wrapping at 8. Descending loop so
  // the smallest offset from p is the last (winning) assignment.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] idx;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (v[idx]) pick = idx;
    end
  endfunction

  logic [7:0] others;
  logic [2:0] idx_inc;
  logic       release_req;
  logic       force_rev;

  assign others      = req & ~(8'b1 << idx_q);
  assign idx_inc     = idx_q + 3'd1;
  assign release_req = !req[idx_q];

`ifdef ARB_TIMEOUT_EN
  // Revoke only when someone else can actually take the resource.
  assign force_rev = (cnt_q == HoldMax) && req[idx_q] && arb_en && (|others);
`else
  assign force_rev = 1'b0;
`endif

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      vld_q   <= 1'b0;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: arbitration, release / back-to-back re-grant, hold counting.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_en && (|req)) begin
          idx_d   = pick(req, ptr_q);
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (release_req || force_rev) begin
          ptr_d = idx_inc;
          cnt_d = '0;
          if (arb_en && (|others)) begin
            // Releasing requester is masked out, so it cannot win this round.
            idx_d = pick(others, idx_inc);
            tmo_d = force_rev;
          end else begin
            vld_d   = 1'b0;
            idx_d   = 3'd0;
            state_d = StIdle;
          end
        end else if (cnt_q != HoldMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: 3-to-8 decode of the registered index, gated by valid.
  always_comb begin
    gnt_vld     = vld_q;
    gnt_idx     = idx_q;
    gnt         = vld_q ? (8'b1 << idx_q) : 8'h00;
    timeout_pls = tmo_q;
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter.
module tb_decoder_rr_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       arb_en;
  logic [7:0] req;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       timeout_pls;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  decoder_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .arb_en      (arb_en),
    .req         (req),
    .gnt_vld     (gnt_vld),
    .gnt_idx     (gnt_idx),
    .gnt         (gnt),
    .timeout_pls (timeout_pls)
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_pulse();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req       = 8'hFF;
    arb_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout_pls !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc%0d: gnt=%h vld=%b idx=%0d tmo=%b, want 00/0/0/0",
                 i, gnt, gnt_vld, gnt_idx, timeout_pls);
      end
    end
    sys_rst_n = 1'b1;
    req       = 8'h00;
    tick();
  endtask

  task automatic test_single();
    req = 8'h04;
    tick();
    checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%h idx=%0d vld=%b, want 04/2/1", gnt, gnt_idx, gnt_vld);
    end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0) begin
      failures++;
      $display("FAIL single_release: gnt=%h vld=%b idx=%0d, want 00/0/0", gnt, gnt_vld, gnt_idx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_gnt;
    reset_pulse();
    req = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_gnt = 8'h01 << i;
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 3'(i) || gnt !== exp_gnt) begin
        failures++;
        $display("FAIL b2b_%0d: gnt=%h idx=%0d vld=%b, want %h/%0d/1",
                 i, gnt, gnt_idx, gnt_vld, exp_gnt, i);
      end
      req[i] = 1'b0;
      tick();
    end
    checks++;
    if (gnt_vld !== 1'b0 || gnt !== 8'h00) begin
      failures++;
      $display("FAIL b2b_end: gnt=%h vld=%b, want 00/0", gnt, gnt_vld);
    end
  endtask

  task automatic test_wrap_fairness();
    req = 8'h40;
    tick();
    checks++;
    if (gnt_idx !== 3'd6 || gnt !== 8'h40) begin
      failures++;
      $display("FAIL wrap_g6: gnt=%h idx=%0d, want 40/6", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
    req = 8'h82;
    tick();
    checks++;
    if (gnt_idx !== 3'd7 || gnt !== 8'h80) begin
      failures++;
      $display("FAIL wrap_g7: gnt=%h idx=%0d, want 80/7", gnt, gnt_idx);
    end
    req = 8'h02;
    tick();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd1 || gnt !== 8'h02) begin
      failures++;
      $display("FAIL wrap_g1: gnt=%h idx=%0d vld=%b, want 02/1/1", gnt, gnt_idx, gnt_vld);
    end
    req = 8'h00;
    tick();
    req = 8'h82;
    tick();
    checks++;
    if (gnt_idx !== 3'd7 || gnt !== 8'h80) begin
      failures++;
      $display("FAIL wrap_ptr2: gnt=%h idx=%0d, want 80/7", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_arb_en();
    arb_en = 1'b0;
    req    = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt_vld !== 1'b0 || gnt !== 8'h00) begin
        failures++;
        $display("FAIL en_block_%0d: gnt=%h vld=%b, want 00/0", i, gnt, gnt_vld);
      end
    end
    arb_en = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL en_grant: gnt=%h vld=%b, want 01/1", gnt, gnt_vld);
    end
    arb_en = 1'b0;
    req    = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== 8'h01) begin
        failures++;
        $display("FAIL en_keep_%0d: gnt=%h, want 01", i, gnt);
      end
    end
    // Release with another requester pending but arb_en low: no re-grant.
    req = 8'h02;
    tick();
    checks++;
    if (gnt_vld !== 1'b0 || gnt !== 8'h00) begin
      failures++;
      $display("FAIL en_noregrant: gnt=%h vld=%b, want 00/0", gnt, gnt_vld);
    end
    req    = 8'h00;
    arb_en = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    reset_pulse();
    req = 8'h09;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt !== ((r == 1) ? 8'h08 : 8'h01) || timeout_pls !== (i == 0 && r > 0)) begin
          failures++;
          $display("FAIL tmo_r%0d_c%0d: gnt=%h tmo=%b", r, i, gnt, timeout_pls);
        end
        tick();
      end
    end
`else
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (gnt !== 8'h01 || timeout_pls !== 1'b0) begin
        failures++;
        $display("FAIL hold_c%0d: gnt=%h tmo=%b, want 01/0", i, gnt, timeout_pls);
      end
      tick();
    end
`endif
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'h20;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      failures++;
      $display("FAIL mid_grant: gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
    end
    sys_rst_n = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout_pls !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: gnt=%h vld=%b idx=%0d tmo=%b, want 00/0/0/0",
               gnt, gnt_vld, gnt_idx, timeout_pls);
    end
    sys_rst_n = 1'b1;
    req       = 8'hFF;
    tick();
    checks++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: gnt=%h idx=%0d vld=%b, want 01/0/1", gnt, gnt_idx, gnt_vld);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    arb_en    = 1'b0;
    req       = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap_fairness();
    test_arb_en();
    test_timeout();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
